// File: rtl/ex_mem_stage_pkg.sv
// Shared processor definitions: ALU op codes and condition-code bit layout.
package ex_mem_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_NOT = 4'd1,
        ALU_LDD = 4'd2,
        ALU_STD = 4'd3
    } alu_op_e;

    // CCR bit positions; the register reads as {C,N,Z}
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    function automatic logic [2:0] pack_ccr(input logic c, input logic n, input logic z);
        logic [2:0] v;
        v        = '0;
        v[CCR_C] = c;
        v[CCR_N] = n;
        v[CCR_Z] = z;
        return v;
    endfunction

endpackage

// File: rtl/ex_mem_stage_ccr_unit.sv
// Condition-code register with interrupt shadow copy and update priority:
// restore > carry override > ALU flag update.
module ccr_unit
    import ex_mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_stall,
    input  logic       i_accept,
    input  logic [3:0] i_op,
    input  logic       i_c,
    input  logic       i_n,
    input  logic       i_z,
    input  logic       i_setc,
    input  logic       i_clrc,
    input  logic       i_save,
    input  logic       i_restore,
    output logic [2:0] o_ccr
);

    logic [2:0] r_ccr;
    logic [2:0] r_shadow;
    logic [2:0] w_upd;
    logic [2:0] w_post;

    // Flag update from the ALU, then the explicit carry override on top of it
    always_comb begin
        w_upd = r_ccr;
        if (i_accept) begin
            case (alu_op_e'(i_op))
                ALU_ADD, ALU_NOT: w_upd = pack_ccr(i_c, i_n, i_z);
                ALU_LDD:          w_upd = pack_ccr(1'b0, i_n, i_z);
                default:          w_upd = r_ccr;
            endcase
        end
        w_post = w_upd;
        // setc and clrc together cancel out and leave C alone
        if (i_accept && (i_setc ^ i_clrc)) begin
            w_post[CCR_C] = i_setc;
        end
    end

    // CCR and shadow registers; a restore on the same edge as a save snapshots the old CCR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr    <= 3'b000;
            r_shadow <= 3'b000;
        end else if (!i_stall) begin
            r_ccr <= i_restore ? r_shadow : w_post;
            if (i_save) begin
                r_shadow <= i_restore ? r_ccr : w_post;
            end
        end
    end

    assign o_ccr = r_ccr;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with condition codes and a forwarding tap.
// Every output comes straight from a flop (or a gate of flops).
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int N  = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  alu_out,
    input  logic          alu_c,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic [3:0]    alu_op,
    input  logic [N-1:0]  st_data,
    input  logic [RW-1:0] rd,
    input  logic          wb_en,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic          setc,
    input  logic          clrc,
    input  logic          int_save,
    input  logic          rti_restore,
    input  logic          stall,
    input  logic          flush,
    output logic          m_valid,
    output logic [N-1:0]  m_addr,
    output logic [N-1:0]  m_data,
    output logic [RW-1:0] m_rd,
    output logic          m_wb_en,
    output logic          m_mem_rd,
    output logic          m_mem_wr,
    output logic [2:0]    ccr,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_rd,
    output logic [N-1:0]  fwd_data
);

    logic          w_accept;
    logic          r_valid;
    logic [N-1:0]  r_addr;
    logic [N-1:0]  r_data;
    logic [RW-1:0] r_rd;
    logic          r_wb_en;
    logic          r_mem_rd;
    logic          r_mem_wr;

    // Flush and an invalid slot both turn into a bubble
    assign w_accept = ~stall & ~flush & in_valid;

    // Pipeline fields; address/data/rd are captured even for bubbles since they are ignored then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rd     <= '0;
            r_wb_en  <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
        end else if (!stall) begin
            r_valid  <= w_accept;
            r_addr   <= alu_out;
            r_data   <= st_data;
            r_rd     <= rd;
            r_wb_en  <= w_accept & wb_en;
            r_mem_rd <= w_accept & mem_rd;
            r_mem_wr <= w_accept & mem_wr;
        end
    end

    ccr_unit u_ccr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_stall   (stall),
        .i_accept  (w_accept),
        .i_op      (alu_op),
        .i_c       (alu_c),
        .i_n       (alu_n),
        .i_z       (alu_z),
        .i_setc    (setc),
        .i_clrc    (clrc),
        .i_save    (int_save),
        .i_restore (rti_restore),
        .o_ccr     (ccr)
    );

    assign m_valid  = r_valid;
    assign m_addr   = r_addr;
    assign m_data   = r_data;
    assign m_rd     = r_rd;
    assign m_wb_en  = r_wb_en;
    assign m_mem_rd = r_mem_rd;
    assign m_mem_wr = r_mem_wr;

    // Loads resolve in the next stage, so they never forward from here
    assign fwd_valid = r_valid & r_wb_en & ~r_mem_rd;
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_addr;

endmodule
